ex_muldiv: RTL and testbench

- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the latched register operands and a decoded HI/LO op, and owns the architectural HI/LO registers.
- MULT/MULTU/DIV/DIVU are multi-cycle. `busy` drives the pipeline stall so the instruction behind the op, and any HI/LO read, waits for the result.
- MTHI/MTLO are single-cycle writes.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/muldiv_negate.sv | 15 +
 rtl/ex_muldiv.sv | 162 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the EX-stage multiply/divide unit.
package cpu_pkg;

  localparam int unsigned MULDIV_DATA_BITS = 32;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_RSVD  = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_FIX  = 2'b11
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate: dout = en ? -din : din.
module muldiv_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    if (en) dout = ~din + {{(WIDTH-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit owning the architectural HI/LO registers.
module ex_muldiv
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_BITS = MULDIV_DATA_BITS,
  parameter int unsigned CNT_BITS  = $clog2(DATA_BITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic                 abort,
  input  logic [DATA_BITS-1:0] rs_val,
  input  logic [DATA_BITS-1:0] rt_val,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] hi,
  output logic [DATA_BITS-1:0] lo
);

  localparam int unsigned W = DATA_BITS;

  muldiv_state_e  state;
  logic [CNT_BITS-1:0] cnt;
  logic [2*W-1:0] prod;
  logic [W-1:0]   b_reg;
  logic [W-1:0]   a_raw;
  logic           neg_res;
  logic           neg_rem;
  logic           is_div;
  logic           div0;

  muldiv_op_e     op_e;
  logic           is_signed;
  logic [W-1:0]   a_abs;
  logic [W-1:0]   b_abs;

  assign op_e      = muldiv_op_e'(op);
  assign is_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
  assign busy      = (state != S_IDLE);

  muldiv_negate #(.WIDTH(W)) u_neg_a (
    .en   (is_signed & rs_val[W-1]),
    .din  (rs_val),
    .dout (a_abs)
  );

  muldiv_negate #(.WIDTH(W)) u_neg_b (
    .en   (is_signed & rt_val[W-1]),
    .din  (rt_val),
    .dout (b_abs)
  );

  // Multiply: multiplier sits in prod low half and is shifted out as the
  // partial sum is shifted in from the top.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  assign mul_sum  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, b_reg} : {(W+1){1'b0}});
  assign mul_next = {mul_sum, prod[W-1:1]};

  // Divide: prod holds {remainder, dividend/quotient}.
  logic [W:0]     rem_sh;
  logic [W:0]     trial;
  logic [2*W-1:0] div_next;
  assign rem_sh   = {prod[2*W-1:W], prod[W-1]};
  assign trial    = rem_sh - {1'b0, b_reg};
  assign div_next = trial[W] ? {rem_sh[W-1:0], prod[W-2:0], 1'b0}
                             : {trial[W-1:0],  prod[W-2:0], 1'b1};

  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;

  muldiv_negate #(.WIDTH(2*W)) u_neg_p (
    .en   (neg_res),
    .din  (prod),
    .dout (prod_fix)
  );

  muldiv_negate #(.WIDTH(W)) u_neg_q (
    .en   (neg_res),
    .din  (prod[W-1:0]),
    .dout (quo_fix)
  );

  muldiv_negate #(.WIDTH(W)) u_neg_r (
    .en   (neg_rem),
    .din  (prod[2*W-1:W]),
    .dout (rem_fix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      prod    <= '0;
      b_reg   <= '0;
      a_raw   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      is_div  <= 1'b0;
      div0    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              case (op_e)
                OP_MTHI: hi <= rs_val;
                OP_MTLO: lo <= rs_val;
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                  prod    <= {{W{1'b0}}, a_abs};
                  b_reg   <= b_abs;
                  a_raw   <= rs_val;
                  neg_res <= is_signed & (rs_val[W-1] ^ rt_val[W-1]);
                  neg_rem <= is_signed & rs_val[W-1];
                  is_div  <= (op_e == OP_DIV) || (op_e == OP_DIVU);
                  div0    <= (rt_val == '0);
                  cnt     <= CNT_BITS'(W - 1);
                  state   <= ((op_e == OP_DIV) || (op_e == OP_DIVU)) ? S_DIV : S_MUL;
                end
                default: ;
              endcase
            end
          end
          S_MUL: begin
            prod <= mul_next;
            if (cnt == '0) state <= S_FIX;
            else           cnt   <= cnt - 1'b1;
          end
          S_DIV: begin
            prod <= div_next;
            if (cnt == '0) state <= S_FIX;
            else           cnt   <= cnt - 1'b1;
          end
          S_FIX: begin
            if (!is_div) begin
              hi <= prod_fix[2*W-1:W];
              lo <= prod_fix[W-1:0];
            end else if (div0) begin
              hi <= a_raw;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed testbench for ex_muldiv: vector table plus abort/reset/MTxx sequences.
module tb_ex_muldiv;

  localparam int unsigned N = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic         abort;
  logic [N-1:0] rs_val;
  logic [N-1:0] rt_val;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  int checks = 0;
  int errors = 0;

  ex_muldiv #(.DATA_BITS(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .abort  (abort),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one start cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; op = 3'b000;
  endtask

  initial begin
    int n;
    int dcount;

    vecs[0] = '{"mult_neg2x3",   3'b001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{"multu_max",     3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{"mult_m1xm1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[3] = '{"multu_2p16sq",  3'b010, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[4] = '{"div_m7_2",      3'b011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[5] = '{"div_7_m2",      3'b011, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[6] = '{"divu_100_7",    3'b100, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[7] = '{"divu_by0",      3'b100, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    vecs[8] = '{"div_m8_by0",    3'b011, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
    vecs[9] = '{"div_ovf",       3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};

    rst_n = 1'b0; start = 1'b0; op = 3'b000; abort = 1'b0; rs_val = '0; rt_val = '0;
    #12;
    chk("reset_hi",   hi,   32'h0);
    chk("reset_lo",   lo,   32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      n = 0;
      while (busy && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk({vecs[i].name, "_busycyc"}, n, 33);
      chk({vecs[i].name, "_done"}, {31'h0, done}, 32'h1);
      chk({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      chk({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
      @(negedge clk);
      chk({vecs[i].name, "_done_once"}, {31'h0, done}, 32'h0);
    end

    // MTLO/MTHI: single-cycle writes, never busy
    issue(3'b110, 32'h00005555, 32'h0);
    chk("mtlo_lo",   lo, 32'h00005555);
    chk("mtlo_busy", {31'h0, busy}, 32'h0);
    issue(3'b101, 32'h12345678, 32'h0);
    chk("mthi_hi",   hi, 32'h12345678);
    chk("mthi_lo",   lo, 32'h00005555);
    chk("mthi_busy", {31'h0, busy}, 32'h0);
    chk("mthi_done", {31'h0, done}, 32'h0);
    issue(3'b101, 32'hAAAA0000, 32'h0);
    chk("mthi2_hi", hi, 32'hAAAA0000);

    // Abort on busy cycle 10
    issue(3'b001, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    chk("abort_no_done", dcount, 0);
    chk("abort_hi", hi, 32'hAAAA0000);
    chk("abort_lo", lo, 32'h00005555);

    // Abort coinciding with the FIX cycle
    issue(3'b010, 32'd2, 32'd3);
    repeat (32) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abortfix_busy", {31'h0, busy}, 32'h0);
    chk("abortfix_done", {31'h0, done}, 32'h0);
    chk("abortfix_hi", hi, 32'hAAAA0000);
    chk("abortfix_lo", lo, 32'h00005555);

    // start + abort in the same cycle
    @(negedge clk);
    start = 1'b1; op = 3'b110; rs_val = 32'hDEADBEEF; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'b000; abort = 1'b0;
    chk("startabort_lo", lo, 32'h00005555);
    start = 1'b1; op = 3'b011; rs_val = 32'd9; rt_val = 32'd3; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'b000; abort = 1'b0;
    chk("startabort_busy", {31'h0, busy}, 32'h0);

    // Reset mid-operation takes effect immediately
    issue(3'b100, 32'd1000, 32'd10);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_hi",   hi, 32'h0);
    chk("midrst_lo",   lo, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_stays_busy", {31'h0, busy}, 32'h0);
    chk("midrst_stays_hi",   hi, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
